// File: rtl/rd_fifo_fill_ctrl.sv
// rtl/rd_fifo_fill_ctrl.sv - read-path FIFO fill controller
// Issues burst/tail reads per line so the video read FIFO never overflows.
module rd_fifo_fill_ctrl #(
   parameter int unsigned DEPTH     = 512,
   parameter int unsigned BURST_LEN = 64,
   parameter int unsigned LSIZE     = 9,
   parameter int unsigned LW        = 16,
   parameter logic [23:0] TIMEOUT   = 24'hFFF000
) (
   input  logic             clock,
   input  logic             rst_n,
   input  logic             enable,
   input  logic             frame_start,
   input  logic [LW-1:0]    line_len,
   input  logic [LW-1:0]    frame_lines,
   input  logic [9:0]       count,
   output logic             burst_req,
   output logic             tail_req,
   output logic [LSIZE-1:0] req_len,
   input  logic             resp,
   input  logic             done,
   output logic             burst_done,
   output logic             tail_done,
   output logic             line_end,
   output logic             frame_end,
   output logic             busy,
   output logic             timeout_err
);

   typedef enum logic [3:0] {
      IDLE, ARM, CHECK, BREQ, BWAIT, TREQ, TWAIT, FSH, NEXTL, TERR
   } state_t;

   localparam logic [23:0] TMAX = TIMEOUT - 24'd1;

   state_t            state, nstate;
   logic [LW-1:0]     rem_words, rem_lines;
   logic [LW-1:0]     line_len_r, frame_lines_r;
   logic [23:0]       tcnt;
   logic              go, frame_pend;
   logic              full_burst, tmo, in_xfer;
   logic [LSIZE-1:0]  nxt;
   logic [31:0]       space;

   assign full_burst = 32'(rem_words) >= BURST_LEN;
   assign nxt        = full_burst ? LSIZE'(BURST_LEN) : LSIZE'(rem_words);
   assign space      = (32'(count) >= DEPTH) ? 32'd0 : DEPTH - 32'(count);
   assign tmo        = (tcnt == TMAX);
   assign in_xfer    = (state == BREQ) || (state == TREQ) ||
                       (state == BWAIT) || (state == TWAIT);

   always_comb begin
      nstate = state;
      unique case (state)
         IDLE:  if (enable && (frame_start || frame_pend)) nstate = ARM;
         ARM:   nstate = CHECK;
         CHECK: begin
            if (frame_start || frame_pend) nstate = ARM;
            else if (!enable)              nstate = IDLE;
            else if (go)                   nstate = full_burst ? BREQ : TREQ;
         end
         BREQ:  if (resp) nstate = BWAIT; else if (tmo) nstate = TERR;
         TREQ:  if (resp) nstate = TWAIT; else if (tmo) nstate = TERR;
         BWAIT: if (done) nstate = FSH;   else if (tmo) nstate = TERR;
         TWAIT: if (done) nstate = FSH;   else if (tmo) nstate = TERR;
         FSH: begin
            if (frame_pend)          nstate = IDLE;
            else if (rem_words != 0) nstate = CHECK;
            else                     nstate = NEXTL;
         end
         NEXTL: nstate = (frame_pend || rem_lines == 0) ? IDLE : CHECK;
         TERR:  nstate = IDLE;
         default: nstate = IDLE;
      endcase
   end

   always_ff @(posedge clock) begin
      if (!rst_n) begin
         state         <= IDLE;
         burst_req     <= 1'b0;
         tail_req      <= 1'b0;
         req_len       <= '0;
         burst_done    <= 1'b0;
         tail_done     <= 1'b0;
         line_end      <= 1'b0;
         frame_end     <= 1'b0;
         busy          <= 1'b0;
         timeout_err   <= 1'b0;
         rem_words     <= '0;
         rem_lines     <= '0;
         line_len_r    <= '0;
         frame_lines_r <= '0;
         tcnt          <= '0;
         go            <= 1'b0;
         frame_pend    <= 1'b0;
      end else begin
         state       <= nstate;
         burst_req   <= (nstate == BREQ);
         tail_req    <= (nstate == TREQ);
         burst_done  <= (state == BWAIT) && (nstate == FSH);
         tail_done   <= (state == TWAIT) && (nstate == FSH);
         line_end    <= (nstate == NEXTL);
         frame_end   <= (nstate == NEXTL) && (rem_lines == LW'(1));
         busy        <= (nstate != IDLE);
         timeout_err <= (nstate == TERR);

         // go only matters in CHECK; forcing it low elsewhere keeps a stale
         // decision from a previous line length out of the first CHECK cycle.
         go   <= (state == CHECK) && enable && (space >= 32'(nxt));
         tcnt <= in_xfer ? tcnt + 24'd1 : 24'd0;

         if (frame_start) begin
            line_len_r    <= line_len;
            frame_lines_r <= frame_lines;
         end
         if (nstate == ARM)    frame_pend <= 1'b0;
         else if (frame_start) frame_pend <= 1'b1;

         if (state == CHECK && (nstate == BREQ || nstate == TREQ))
            req_len <= nxt;

         case (state)
            ARM: begin
               rem_words <= line_len_r;
               rem_lines <= frame_lines_r;
            end
            BWAIT, TWAIT: if (nstate == FSH) rem_words <= rem_words - LW'(req_len);
            NEXTL: rem_words <= line_len_r;
            TERR: begin
               rem_words <= '0;
               rem_lines <= '0;
            end
            default: ;
         endcase
         if (nstate == NEXTL) rem_lines <= rem_lines - LW'(1);
      end
   end

endmodule

// File: tb/tb_rd_fifo_fill_ctrl.sv
// tb/tb_rd_fifo_fill_ctrl.sv - directed bench for rd_fifo_fill_ctrl
module tb_rd_fifo_fill_ctrl;
   localparam int LSIZE = 9;
   localparam int LW    = 16;

   logic             clock;
   logic             rst_n, enable, frame_start, resp, done;
   logic [LW-1:0]    line_len, frame_lines;
   logic [9:0]       count;
   logic             burst_req, tail_req, burst_done, tail_done;
   logic             line_end, frame_end, busy, timeout_err;
   logic [LSIZE-1:0] req_len;

   int checks = 0;
   int failures = 0;
   int n_breq, n_treq, n_bdone, n_tdone, n_lend, n_fend, n_fe_le, n_terr, n_req;
   int req_log[16];
   bit tail_log[16];
   bit prev_breq, prev_treq, auto_resp, hold_done, outstanding;
   int rd_wait;

   rd_fifo_fill_ctrl #(
      .DEPTH(512), .BURST_LEN(64), .LSIZE(LSIZE), .LW(LW), .TIMEOUT(24'd1000)
   ) dut (
      .clock(clock), .rst_n(rst_n), .enable(enable), .frame_start(frame_start),
      .line_len(line_len), .frame_lines(frame_lines), .count(count),
      .burst_req(burst_req), .tail_req(tail_req), .req_len(req_len),
      .resp(resp), .done(done), .burst_done(burst_done), .tail_done(tail_done),
      .line_end(line_end), .frame_end(frame_end), .busy(busy),
      .timeout_err(timeout_err)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   // Advance one cycle, sample outputs 1 time unit after the edge, then play
   // the read-master responder (resp/done about 2 cycles after each event).
   task automatic tick();
      @(posedge clock); #1;
      if (burst_done) n_bdone++;
      if (tail_done) n_tdone++;
      if (line_end) n_lend++;
      if (frame_end) n_fend++;
      if (frame_end && line_end) n_fe_le++;
      if (timeout_err) n_terr++;
      if ((burst_req && !prev_breq) || (tail_req && !prev_treq)) begin
         if (n_req < 16) begin
            req_log[n_req] = int'(req_len);
            tail_log[n_req] = tail_req;
         end
         n_req++;
      end
      if (burst_req && !prev_breq) n_breq++;
      if (tail_req && !prev_treq) n_treq++;
      prev_breq = burst_req;
      prev_treq = tail_req;
      if (auto_resp) begin
         resp = 1'b0;
         done = 1'b0;
         if (outstanding) begin
            if (rd_wait == 2) begin
               if (!hold_done) begin
                  done = 1'b1;
                  outstanding = 1'b0;
               end
               rd_wait = 0;
            end else rd_wait++;
         end else if (burst_req || tail_req) begin
            if (rd_wait == 2) begin
               resp = 1'b1;
               outstanding = 1'b1;
               rd_wait = 0;
            end else rd_wait++;
         end
      end
   endtask

   task automatic clr_counts();
      n_breq = 0; n_treq = 0; n_bdone = 0; n_tdone = 0; n_lend = 0;
      n_fend = 0; n_fe_le = 0; n_terr = 0; n_req = 0;
      prev_breq = 0; prev_treq = 0; outstanding = 0; rd_wait = 0;
      for (int i = 0; i < 16; i++) begin
         req_log[i] = 0;
         tail_log[i] = 0;
      end
   endtask

   task automatic do_reset();
      auto_resp = 0; hold_done = 0; resp = 0; done = 0; frame_start = 0;
      rst_n = 0;
      tick(); tick();
      rst_n = 1;
      clr_counts();
   endtask

   task automatic start_frame(input int len, input int lines);
      line_len = LW'(len);
      frame_lines = LW'(lines);
      frame_start = 1;
      tick();
      frame_start = 0;
   endtask

   task automatic wait_frame_end(input int budget);
      for (int i = 0; i < budget && n_fend == 0 && n_terr == 0; i++) tick();
      tick(); tick(); tick();
   endtask

   task automatic test_reset();
      rst_n = 0; enable = 1; frame_start = 1; resp = 0; done = 0;
      auto_resp = 0; hold_done = 0; count = 0; line_len = 16; frame_lines = 1;
      clr_counts();
      tick(); tick(); tick();
      checks++; if ({burst_req, tail_req, burst_done, tail_done, line_end, frame_end, busy, timeout_err} !== 8'b0) begin failures++; $display("FAIL reset_outputs got=%b exp=00000000", {burst_req, tail_req, burst_done, tail_done, line_end, frame_end, busy, timeout_err}); end
      checks++; if (req_len !== '0) begin failures++; $display("FAIL reset_req_len got=%0d exp=0", req_len); end
      frame_start = 0;
      rst_n = 1;
      for (int i = 0; i < 5; i++) tick();
      checks++; if (busy !== 1'b0 || n_req !== 0) begin failures++; $display("FAIL reset_no_pend busy=%b reqs=%0d exp busy=0 reqs=0", busy, n_req); end
   endtask

   task automatic test_frame();
      do_reset();
      enable = 1; count = 0; auto_resp = 1;
      start_frame(200, 2);
      wait_frame_end(600);
      checks++; if (n_breq !== 6) begin failures++; $display("FAIL frame_burst_req got=%0d exp=6", n_breq); end
      checks++; if (n_treq !== 2) begin failures++; $display("FAIL frame_tail_req got=%0d exp=2", n_treq); end
      checks++; if (n_bdone !== 6) begin failures++; $display("FAIL frame_burst_done got=%0d exp=6", n_bdone); end
      checks++; if (n_tdone !== 2) begin failures++; $display("FAIL frame_tail_done got=%0d exp=2", n_tdone); end
      checks++; if (n_lend !== 2) begin failures++; $display("FAIL frame_line_end got=%0d exp=2", n_lend); end
      checks++; if (n_fend !== 1) begin failures++; $display("FAIL frame_frame_end got=%0d exp=1", n_fend); end
      checks++; if (busy !== 1'b0) begin failures++; $display("FAIL frame_idle_busy got=%b exp=0", busy); end
      for (int i = 0; i < 8; i++) begin
         checks++;
         if (req_log[i] !== ((i % 4 == 3) ? 8 : 64) || tail_log[i] !== (i % 4 == 3)) begin
            failures++;
            $display("FAIL frame_req[%0d] got len=%0d tail=%0d exp len=%0d tail=%0d", i, req_log[i], tail_log[i], (i % 4 == 3) ? 8 : 64, (i % 4 == 3));
         end
      end
   endtask

   task automatic test_space();
      do_reset();
      enable = 1; count = 10'd460; auto_resp = 1;
      start_frame(200, 1);
      for (int i = 0; i < 20; i++) tick();
      checks++; if (n_req !== 0 || busy !== 1'b1) begin failures++; $display("FAIL space_hold reqs=%0d busy=%b exp reqs=0 busy=1", n_req, busy); end
      count = 10'd448;
      tick();
      checks++; if (burst_req !== 1'b0) begin failures++; $display("FAIL space_lat1 got=%b exp=0", burst_req); end
      tick();
      checks++; if (burst_req !== 1'b1 || req_len !== 9'd64) begin failures++; $display("FAIL space_lat2 burst_req=%b req_len=%0d exp 1/64", burst_req, req_len); end
      wait_frame_end(600);
      checks++; if (n_breq !== 3 || n_treq !== 1 || n_fend !== 1) begin failures++; $display("FAIL space_frame breq=%0d treq=%0d fend=%0d exp 3/1/1", n_breq, n_treq, n_fend); end
      count = 0;
   endtask

   task automatic test_exact_multiple();
      do_reset();
      enable = 1; count = 0; auto_resp = 1;
      start_frame(128, 1);
      wait_frame_end(400);
      checks++; if (n_breq !== 2) begin failures++; $display("FAIL exact_burst_req got=%0d exp=2", n_breq); end
      checks++; if (n_treq !== 0) begin failures++; $display("FAIL exact_tail_req got=%0d exp=0", n_treq); end
      checks++; if (n_fend !== 1 || n_lend !== 1 || n_fe_le !== 1) begin failures++; $display("FAIL exact_frame_end fend=%0d lend=%0d coincide=%0d exp 1/1/1", n_fend, n_lend, n_fe_le); end
   endtask

   task automatic test_timeout();
      int hi;
      do_reset();
      enable = 1; count = 0; auto_resp = 0; resp = 0; done = 0;
      start_frame(200, 1);
      for (int i = 0; i < 50 && !burst_req; i++) tick();
      hi = burst_req ? 1 : 0;
      for (int i = 0; i < 1100; i++) begin
         tick();
         if (timeout_err) break;
         if (burst_req) hi++;
      end
      checks++; if (hi !== 1000) begin failures++; $display("FAIL timeout_req_cycles got=%0d exp=1000", hi); end
      checks++; if (timeout_err !== 1'b1 || burst_req !== 1'b0) begin failures++; $display("FAIL timeout_pulse err=%b burst_req=%b exp 1/0", timeout_err, burst_req); end
      tick();
      checks++; if (busy !== 1'b0 || timeout_err !== 1'b0) begin failures++; $display("FAIL timeout_after busy=%b err=%b exp 0/0", busy, timeout_err); end
      tick(); tick();
      checks++; if (n_fend !== 0 || n_lend !== 0 || n_terr !== 1) begin failures++; $display("FAIL timeout_no_end fend=%0d lend=%0d terr=%0d exp 0/0/1", n_fend, n_lend, n_terr); end
   endtask

   task automatic test_restart_in_wait();
      bit saw_idle;
      do_reset();
      enable = 1; count = 0; auto_resp = 1;
      start_frame(200, 2);
      for (int i = 0; i < 50 && !burst_req; i++) tick();
      for (int i = 0; i < 50 && burst_req; i++) tick();
      line_len = 40; frame_lines = 1; frame_start = 1;
      tick();
      frame_start = 0;
      saw_idle = 0;
      for (int i = 0; i < 60 && n_treq == 0; i++) begin
         tick();
         if (!busy) saw_idle = 1;
      end
      checks++; if (n_bdone !== 1) begin failures++; $display("FAIL restart_burst_done got=%0d exp=1", n_bdone); end
      checks++; if (saw_idle !== 1'b1) begin failures++; $display("FAIL restart_idle got=%b exp=1", saw_idle); end
      checks++; if (n_breq !== 1 || n_treq !== 1 || req_log[1] !== 40) begin failures++; $display("FAIL restart_new_len breq=%0d treq=%0d len=%0d exp 1/1/40", n_breq, n_treq, req_log[1]); end
      wait_frame_end(200);
      checks++; if (n_fend !== 1 || n_lend !== 1 || n_tdone !== 1) begin failures++; $display("FAIL restart_frame fend=%0d lend=%0d tdone=%0d exp 1/1/1", n_fend, n_lend, n_tdone); end
   endtask

   task automatic test_reset_in_twait();
      do_reset();
      enable = 1; count = 0; auto_resp = 1; hold_done = 1;
      start_frame(8, 1);
      for (int i = 0; i < 50 && !tail_req; i++) tick();
      for (int i = 0; i < 50 && tail_req; i++) tick();
      checks++; if (busy !== 1'b1 || req_len !== 9'd8) begin failures++; $display("FAIL twait_state busy=%b req_len=%0d exp 1/8", busy, req_len); end
      rst_n = 0;
      tick();
      checks++; if (tail_req !== 1'b0 || busy !== 1'b0 || req_len !== '0) begin failures++; $display("FAIL twait_reset tail_req=%b busy=%b req_len=%0d exp 0/0/0", tail_req, busy, req_len); end
      rst_n = 1; auto_resp = 0; hold_done = 0; resp = 0; done = 0;
      tick();
      done = 1;
      tick();
      done = 0;
      tick(); tick();
      checks++; if (n_tdone !== 0 || busy !== 1'b0) begin failures++; $display("FAIL twait_late_done tdone=%0d busy=%b exp 0/0", n_tdone, busy); end
   endtask

   initial begin
      test_reset();
      test_frame();
      test_space();
      test_exact_multiple();
      test_timeout();
      test_restart_in_wait();
      test_reset_in_twait();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
